// File: rtl/ntr_cmd_port_if.sv
// NTR cartridge-bus pins plus the command/response handshakes of ntr_cmd_port.
// The slave modport is the port block itself; master is whatever drives the pins and the response source.
interface ntr_cmd_port_if;
    logic        ntr_clk;
    logic        ntr_cs1;
    logic [7:0]  ntr_data_i;
    logic [7:0]  ntr_data_o;
    logic        ntr_data_oe;
    logic [63:0] cmd;
    logic        cmd_valid;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_underrun;
    logic        xfer_abort;
    logic        busy;

    modport slave (
        input  ntr_clk, ntr_cs1, ntr_data_i, rsp_data, rsp_valid,
        output ntr_data_o, ntr_data_oe, cmd, cmd_valid,
               rsp_ready, rsp_underrun, xfer_abort, busy
    );

    modport master (
        output ntr_clk, ntr_cs1, ntr_data_i, rsp_data, rsp_valid,
        input  ntr_data_o, ntr_data_oe, cmd, cmd_valid,
               rsp_ready, rsp_underrun, xfer_abort, busy
    );
endinterface

// File: rtl/ntr_cmd_port.sv
// NTR bus slave front end: synchronises the card pins, captures the 8-byte command
// and then streams response bytes out on every ntr_clk falling edge until deselect.
module ntr_cmd_port #(
    parameter int unsigned SKIP_EDGES = 1,
    parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
    input  logic          clk,
    input  logic          rst_n,
    ntr_cmd_port_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SKIP, CMD, RSP} state_t;

    localparam logic [1:0] SKIP_INIT = 2'(SKIP_EDGES);

    state_t      state, state_nxt;
    logic        clk_s1, clk_s2, clk_prev;
    logic        cs_s1, cs_s2, cs_prev;
    logic [7:0]  data_s1, data_s2;
    logic [1:0]  sync_vld;
    logic        armed;
    logic [1:0]  skip_cnt, skip_cnt_nxt;
    logic [3:0]  byte_cnt, byte_cnt_nxt;
    logic [63:0] shift_q, shift_nxt;
    logic [63:0] cmd_q, cmd_nxt;
    logic [7:0]  data_o_q, data_o_nxt;
    logic        oe_q, oe_nxt;
    logic        cmd_valid_q, cmd_valid_nxt;
    logic        abort_q, abort_nxt;
    logic        rsp_ready_c, underrun_c;
    logic        clk_rise, clk_fall, cs_rise;

    assign clk_rise = clk_s2 & ~clk_prev;
    assign clk_fall = ~clk_s2 & clk_prev;
    assign cs_rise  = cs_s2 & ~cs_prev;

    // sync_vld marks when cs_s2 holds a real pin sample rather than its reset value,
    // so a reset taken while selected cannot arm on the reset value and capture a partial command.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_prev <= 1'b0;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            cs_prev  <= 1'b1;
            data_s1  <= 8'h00;
            data_s2  <= 8'h00;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            clk_s1   <= bus.ntr_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            cs_s1    <= bus.ntr_cs1;
            cs_s2    <= cs_s1;
            cs_prev  <= cs_s2;
            data_s1  <= bus.ntr_data_i;
            data_s2  <= data_s1;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && cs_s2) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            skip_cnt    <= 2'd0;
            byte_cnt    <= 4'd0;
            shift_q     <= 64'd0;
            cmd_q       <= 64'd0;
            data_o_q    <= 8'h00;
            oe_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            skip_cnt    <= skip_cnt_nxt;
            byte_cnt    <= byte_cnt_nxt;
            shift_q     <= shift_nxt;
            cmd_q       <= cmd_nxt;
            data_o_q    <= data_o_nxt;
            oe_q        <= oe_nxt;
            cmd_valid_q <= cmd_valid_nxt;
            abort_q     <= abort_nxt;
        end
    end

    // Deselect outranks any ntr_clk edge seen in the same cycle.
    always_comb begin
        state_nxt     = state;
        skip_cnt_nxt  = skip_cnt;
        byte_cnt_nxt  = byte_cnt;
        shift_nxt     = shift_q;
        cmd_nxt       = cmd_q;
        data_o_nxt    = data_o_q;
        oe_nxt        = oe_q;
        cmd_valid_nxt = 1'b0;
        abort_nxt     = 1'b0;
        rsp_ready_c   = 1'b0;
        underrun_c    = 1'b0;

        if (state != IDLE && cs_rise) begin
            state_nxt    = IDLE;
            oe_nxt       = 1'b0;
            byte_cnt_nxt = 4'd0;
            skip_cnt_nxt = 2'd0;
            if (state == SKIP || (state == CMD && byte_cnt < 4'd8)) begin
                abort_nxt = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (armed && !cs_s2) begin
                        byte_cnt_nxt = 4'd0;
                        if (SKIP_INIT == 2'd0) begin
                            state_nxt = CMD;
                        end else begin
                            state_nxt    = SKIP;
                            skip_cnt_nxt = SKIP_INIT;
                        end
                    end
                end
                SKIP: begin
                    if (clk_rise) begin
                        skip_cnt_nxt = skip_cnt - 2'd1;
                        if (skip_cnt == 2'd1) begin
                            state_nxt    = CMD;
                            byte_cnt_nxt = 4'd0;
                        end
                    end
                end
                CMD: begin
                    if (clk_rise) begin
                        shift_nxt    = {shift_q[55:0], data_s2};
                        byte_cnt_nxt = byte_cnt + 4'd1;
                        if (byte_cnt == 4'd7) begin
                            cmd_nxt       = {shift_q[55:0], data_s2};
                            cmd_valid_nxt = 1'b1;
                            state_nxt     = RSP;
                        end
                    end
                end
                RSP: begin
                    if (clk_fall) begin
                        oe_nxt = 1'b1;
                        if (bus.rsp_valid) begin
                            data_o_nxt  = bus.rsp_data;
                            rsp_ready_c = 1'b1;
                        end else begin
                            data_o_nxt = FILL_BYTE;
                            underrun_c = 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // rsp_ready and rsp_underrun are combinational so the source advances on the same edge that loads ntr_data_o.
    assign bus.rsp_ready    = rsp_ready_c & rst_n;
    assign bus.rsp_underrun = underrun_c & rst_n;
    assign bus.ntr_data_o   = data_o_q;
    assign bus.ntr_data_oe  = oe_q;
    assign bus.cmd          = cmd_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.xfer_abort   = abort_q;
    assign bus.busy         = (state != IDLE);

endmodule
